// File: rtl/settings_arbiter.sv
// Round-robin arbiter sharing one settings bus (strobe/addr/data) between NREQ
// write requesters, with per-requester burst lock and a programmable post-write gap.
module settings_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 strobe,
  output logic [6:0]           addr,
  output logic [31:0]          data,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  grantId_q, grantId_d;
  logic [2:0]  rr_q, rr_d;
  logic        lockValid_q, lockValid_d;
  logic [2:0]  lockOwner_q, lockOwner_d;
  logic [3:0]  gapCnt_q, gapCnt_d;

  logic [7:0]  reqPad;
  logic [7:0]  lockPad;
  logic [6:0]  addrArr [8];
  logic [31:0] dataArr [8];
  logic        rrFound;
  logic [2:0]  rrWin;
  logic [3:0]  cand;
  logic        ownerWins;

  // Widen the requester buses to 8 slots so a 3-bit index is always legal.
  always_comb begin
    reqPad  = '0;
    lockPad = '0;
    for (int i = 0; i < 8; i++) begin
      addrArr[i] = '0;
      dataArr[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      reqPad[i]  = req[i];
      lockPad[i] = lock[i];
      addrArr[i] = req_addr[7*i +: 7];
      dataArr[i] = req_data[32*i +: 32];
    end
  end

  always_comb begin
    rrFound = 1'b0;
    rrWin   = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!rrFound && reqPad[cand[2:0]]) begin
        rrFound = 1'b1;
        rrWin   = cand[2:0];
      end
    end
  end

  assign ownerWins = lockValid_q && reqPad[lockOwner_q];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    grantId_d   = grantId_q;
    rr_d        = rr_q;
    lockValid_d = lockValid_q;
    lockOwner_d = lockOwner_q;
    gapCnt_d    = gapCnt_q;
    case (state_q)
      IDLE: begin
        if (ownerWins) begin
          state_d   = ISSUE;
          grantId_d = lockOwner_q;
          addr_d    = addrArr[lockOwner_q];
          data_d    = dataArr[lockOwner_q];
        end else begin
          // An owner that dropped req loses the lock; round-robin runs this cycle.
          lockValid_d = 1'b0;
          if (rrFound) begin
            state_d   = ISSUE;
            grantId_d = rrWin;
            addr_d    = addrArr[rrWin];
            data_d    = dataArr[rrWin];
            rr_d      = (rrWin == 3'(NREQ-1)) ? 3'd0 : rrWin + 3'd1;
          end
        end
      end
      ISSUE: begin
        lockValid_d = lockPad[grantId_q];
        lockOwner_d = grantId_q;
        if (GAP > 0) begin
          state_d  = HOLD;
          gapCnt_d = 4'(GAP);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (gapCnt_q <= 4'd1) begin
          state_d  = IDLE;
          gapCnt_d = '0;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      grantId_q   <= '0;
      rr_q        <= '0;
      lockValid_q <= 1'b0;
      lockOwner_q <= '0;
      gapCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      grantId_q   <= grantId_d;
      rr_q        <= rr_d;
      lockValid_q <= lockValid_d;
      lockOwner_q <= lockOwner_d;
      gapCnt_q    <= gapCnt_d;
    end
  end

  // Strobe and ack decode straight from state so an async reset kills them at once.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (state_q == ISSUE && grantId_q == 3'(i)) ack[i] = 1'b1;
    end
  end

  assign strobe   = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign addr     = addr_q;
  assign data     = data_q;
  assign grant_id = grantId_q;

endmodule

// File: tb/tb_settings_arbiter.sv
// Directed self-checking bench for settings_arbiter: one GAP=0 instance for
// arbitration/lock/reset behaviour and one GAP=3 instance for gap timing.
module tb_settings_arbiter;
  localparam int NREQ = 4;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req, lock, ack;
  logic [7*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_data;
  logic              strobe, busy;
  logic [6:0]        addr;
  logic [31:0]       data;
  logic [2:0]        grant_id;

  logic [NREQ-1:0]    reqG, lockG, ackG;
  logic [7*NREQ-1:0]  reqAddrG;
  logic [32*NREQ-1:0] reqDataG;
  logic               strobeG, busyG;
  logic [6:0]         addrG;
  logic [31:0]        dataG;
  logic [2:0]         grantIdG;

  int totalChecks = 0;
  int badChecks   = 0;
  logic [6:0]  addrTab [NREQ];
  logic [31:0] dataTab [NREQ];

  settings_arbiter #(.NREQ(NREQ), .GAP(0)) dut (
    .clock(clock), .reset(reset), .req(req), .lock(lock),
    .req_addr(req_addr), .req_data(req_data), .ack(ack), .strobe(strobe),
    .addr(addr), .data(data), .grant_id(grant_id), .busy(busy)
  );

  settings_arbiter #(.NREQ(NREQ), .GAP(3)) dutGap (
    .clock(clock), .reset(reset), .req(reqG), .lock(lockG),
    .req_addr(reqAddrG), .req_data(reqDataG), .ack(ackG), .strobe(strobeG),
    .addr(addrG), .data(dataG), .grant_id(grantIdG), .busy(busyG)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic r, input logic l,
                               input logic [6:0] a, input logic [31:0] d);
    req[idx]              = r;
    lock[idx]             = l;
    req_addr[7*idx +: 7]  = a;
    req_data[32*idx +: 32] = d;
    addrTab[idx]          = a;
    dataTab[idx]          = d;
  endtask

  task automatic doReset;
    req = '0; lock = '0; req_addr = '0; req_data = '0;
    reqG = '0; lockG = '0; reqAddrG = '0; reqDataG = '0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  // Waits (bounded) for the next strobe, checks the grant, then steps past ISSUE.
  task automatic expectGrant(input string tag, input int id, input int cycles);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (strobe !== 1'b1 && n < cycles + 4);
    checkOutput({tag, "_lat"}, 32'(n), 32'(cycles));
    checkOutput({tag, "_gid"}, 32'(grant_id), 32'(id));
    checkOutput({tag, "_ack"}, 32'(ack), 32'(1) << id);
    checkOutput({tag, "_addr"}, 32'(addr), 32'(addrTab[id]));
    checkOutput({tag, "_data"}, data, dataTab[id]);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    tick;
    checkOutput({tag, "_stbOff"}, 32'(strobe), 32'd0);
    checkOutput({tag, "_ackOff"}, 32'(ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int busyCnt;
    int strobeCnt;
    reset = 1'b0;
    req = '0; lock = '0; req_addr = '0; req_data = '0;
    reqG = '0; lockG = '0; reqAddrG = '0; reqDataG = '0;
    tick;
    tick;
    checkOutput("rst_strobe", 32'(strobe), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_data", data, 32'd0);
    checkOutput("rst_gid", 32'(grant_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Single write from requester 2
    applyStimulus(2, 1'b1, 1'b0, 7'd5, 32'hDEADBEEF);
    expectGrant("single", 2, 1);
    checkOutput("single_busyOff", 32'(busy), 32'd0);
    checkOutput("single_addrHold", 32'(addr), 32'd5);
    checkOutput("single_dataHold", data, 32'hDEADBEEF);
    applyStimulus(2, 1'b0, 1'b0, 7'd5, 32'hDEADBEEF);

    // Wrap: pointer is now 3
    applyStimulus(3, 1'b1, 1'b0, 7'h33, 32'h3333_0001);
    applyStimulus(0, 1'b1, 1'b0, 7'h10, 32'h1000_0001);
    expectGrant("wrap3", 3, 1);
    applyStimulus(3, 1'b0, 1'b0, 7'h33, 32'h3333_0001);
    expectGrant("wrap0", 0, 1);
    applyStimulus(0, 1'b1, 1'b0, 7'h11, 32'h1000_0002);
    expectGrant("wrapP1", 0, 1);
    applyStimulus(0, 1'b0, 1'b0, 7'h11, 32'h1000_0002);

    // Round-robin with all four requesting and re-presenting after ack
    doReset;
    for (int i = 0; i < NREQ; i++)
      applyStimulus(i, 1'b1, 1'b0, 7'(7'h20 + i), 32'hAB00_0000 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      expectGrant($sformatf("rr%0d", k), k % NREQ, 1);
      applyStimulus(k % NREQ, 1'b1, 1'b0, 7'(7'h28 + k), 32'hCD00_0000 + 32'(k));
    end

    // Lock burst by requester 1 while requester 0 keeps requesting
    doReset;
    applyStimulus(0, 1'b1, 1'b0, 7'h40, 32'h4000_0000);
    expectGrant("lk0", 0, 1);
    applyStimulus(0, 1'b1, 1'b0, 7'h41, 32'h4000_0001);
    applyStimulus(1, 1'b1, 1'b1, 7'h50, 32'h5000_0001);
    expectGrant("lk1a", 1, 1);
    applyStimulus(1, 1'b1, 1'b1, 7'h51, 32'h5000_0002);
    expectGrant("lk1b", 1, 1);
    applyStimulus(1, 1'b1, 1'b0, 7'h52, 32'h5000_0003);
    expectGrant("lk1c", 1, 1);
    applyStimulus(1, 1'b1, 1'b0, 7'h53, 32'h5000_0004);
    expectGrant("lkRel", 0, 1);

    // Gap timing on the GAP=3 instance
    doReset;
    reqG[0] = 1'b1;
    reqAddrG[6:0] = 7'h60;
    reqDataG[31:0] = 32'h6000_0000;
    n = 0;
    do begin
      tick;
      n++;
    end while (strobeG !== 1'b1 && n < 5);
    checkOutput("gap_firstLat", 32'(n), 32'd1);
    checkOutput("gap_ack", 32'(ackG), 32'd1);
    checkOutput("gap_addr", 32'(addrG), 32'h60);
    for (int p = 0; p < 2; p++) begin
      busyCnt = 0;
      strobeCnt = 0;
      for (int c = 0; c < 5; c++) begin
        busyCnt += int'(busyG);
        strobeCnt += int'(strobeG);
        tick;
      end
      checkOutput($sformatf("gap_strobeAgain%0d", p), 32'(strobeG), 32'd1);
      checkOutput($sformatf("gap_busyCnt%0d", p), 32'(busyCnt), 32'd4);
      checkOutput($sformatf("gap_strobeCnt%0d", p), 32'(strobeCnt), 32'd1);
    end
    reqG = '0;

    // Async reset in the middle of an ISSUE cycle
    doReset;
    applyStimulus(0, 1'b1, 1'b0, 7'h70, 32'h7777_0000);
    tick;
    checkOutput("ar_strobeOn", 32'(strobe), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("ar_strobe", 32'(strobe), 32'd0);
    checkOutput("ar_ack", 32'(ack), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_addr", 32'(addr), 32'd0);
    checkOutput("ar_data", data, 32'd0);
    #2 reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 7'h70, 32'h7777_0000);
    applyStimulus(1, 1'b1, 1'b0, 7'h71, 32'h7777_0001);
    expectGrant("arReq1", 1, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
